// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - shared encodings and timing defaults for the DDR init monitor
package ddr_pkg;

    typedef enum logic [3:0] {
        ST_WAIT_CKE = 4'd0,
        ST_NOP_HOLD = 4'd1,
        ST_PRE1     = 4'd2,
        ST_EMR      = 4'd3,
        ST_MR1      = 4'd4,
        ST_PRE2     = 4'd5,
        ST_REF1     = 4'd6,
        ST_REF2     = 4'd7,
        ST_MR2      = 4'd8,
        ST_READY    = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        LAST_NONE,
        LAST_PRE,
        LAST_LMR,
        LAST_REF
    } last_t;

    // {RAS,CAS,WE} pin encodings
    localparam logic [2:0] RCW_NOP = 3'b111;
    localparam logic [2:0] RCW_ACT = 3'b011;
    localparam logic [2:0] RCW_RD  = 3'b101;
    localparam logic [2:0] RCW_WR  = 3'b100;
    localparam logic [2:0] RCW_PRE = 3'b010;
    localparam logic [2:0] RCW_REF = 3'b001;
    localparam logic [2:0] RCW_LMR = 3'b000;
    localparam logic [2:0] RCW_BST = 3'b110;

    localparam int CMD_N   = 8;
    localparam int CMD_NOP = 0;
    localparam int CMD_ACT = 1;
    localparam int CMD_RD  = 2;
    localparam int CMD_WR  = 3;
    localparam int CMD_PRE = 4;
    localparam int CMD_REF = 5;
    localparam int CMD_LMR = 6;
    localparam int CMD_BST = 7;

    localparam logic [3:0] ERR_NONE       = 4'd0;
    localparam logic [3:0] ERR_CKE_EARLY  = 4'd1;
    localparam logic [3:0] ERR_SEQ        = 4'd2;
    localparam logic [3:0] ERR_TRP        = 4'd3;
    localparam logic [3:0] ERR_TMRD       = 4'd4;
    localparam logic [3:0] ERR_TRFC       = 4'd5;
    localparam logic [3:0] ERR_LMR_VAL    = 4'd6;
    localparam logic [3:0] ERR_ROW_OPEN   = 4'd7;
    localparam logic [3:0] ERR_ROW_CLOSED = 4'd8;
    localparam logic [3:0] ERR_TREFI      = 4'd9;
    localparam logic [3:0] ERR_PRE_A10    = 4'd10;
    localparam logic [3:0] ERR_CKE_LOW    = 4'd11;

    localparam int          DEF_INIT_CYCLES = 26600;
    localparam int          DEF_T_RP        = 3;
    localparam int          DEF_T_MRD       = 2;
    localparam int          DEF_T_RFC       = 11;
    localparam int          DEF_T_REFI      = 1037;
    localparam logic [12:0] DEF_MR_VALUE    = 13'h0021;
    localparam logic [12:0] DEF_EMR_VALUE   = 13'h0000;

    localparam int GAP_W = 8;

endpackage

// File: rtl/ddr_cmd_decode.sv
// rtl/ddr_cmd_decode.sv - maps DDR command pins to a one-hot command vector
module ddr_cmd_decode
    import ddr_pkg::*;
(
    input  logic             i_cs,
    input  logic             i_ras,
    input  logic             i_cas,
    input  logic             i_we,
    output logic [CMD_N-1:0] o_cmd
);

    always_comb begin
        o_cmd = '0;
        if (i_cs) begin
            o_cmd[CMD_NOP] = 1'b1;
        end else begin
            case ({i_ras, i_cas, i_we})
                RCW_NOP: o_cmd[CMD_NOP] = 1'b1;
                RCW_ACT: o_cmd[CMD_ACT] = 1'b1;
                RCW_RD:  o_cmd[CMD_RD]  = 1'b1;
                RCW_WR:  o_cmd[CMD_WR]  = 1'b1;
                RCW_PRE: o_cmd[CMD_PRE] = 1'b1;
                RCW_REF: o_cmd[CMD_REF] = 1'b1;
                RCW_LMR: o_cmd[CMD_LMR] = 1'b1;
                RCW_BST: o_cmd[CMD_BST] = 1'b1;
                default: o_cmd[CMD_NOP] = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ddr_init_monitor.sv
// rtl/ddr_init_monitor.sv - checks the DDR power-up sequence and post-init bank usage
module ddr_init_monitor
    import ddr_pkg::*;
#(
    parameter int          INIT_CYCLES = DEF_INIT_CYCLES,
    parameter int          T_RP        = DEF_T_RP,
    parameter int          T_MRD       = DEF_T_MRD,
    parameter int          T_RFC       = DEF_T_RFC,
    parameter int          T_REFI      = DEF_T_REFI,
    parameter logic [12:0] MR_VALUE    = DEF_MR_VALUE,
    parameter logic [12:0] EMR_VALUE   = DEF_EMR_VALUE
) (
    input  logic        clk133_p,
    input  logic        rst,
    input  logic        sd_CKE,
    input  logic        sd_CS,
    input  logic        sd_RAS,
    input  logic        sd_CAS,
    input  logic        sd_WE,
    input  logic [1:0]  sd_BA,
    input  logic [12:0] sd_A,
    output logic        init_done,
    output logic        err,
    output logic [3:0]  err_code,
    output logic [3:0]  row_open,
    output logic [3:0]  state
);

    localparam int CNT_W = $clog2(INIT_CYCLES + T_REFI + 2);
    localparam logic [CNT_W-1:0] INIT_LIM = CNT_W'(INIT_CYCLES);
    localparam logic [CNT_W-1:0] REFI_LIM = CNT_W'(T_REFI);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [GAP_W-1:0] RP_LIM   = GAP_W'(T_RP);
    localparam logic [GAP_W-1:0] MRD_LIM  = GAP_W'(T_MRD);
    localparam logic [GAP_W-1:0] RFC_LIM  = GAP_W'(T_RFC);

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [GAP_W-1:0]  r_gap;
    last_t             r_last;
    logic              r_err;
    logic [3:0]        r_err_code;
    logic              r_init_done;
    logic [3:0]        r_row_open;
    logic [3:0]        w_row_next;
    logic [11:1]       w_flag;
    logic [3:0]        w_code;
    logic              w_done_set;
    logic [CMD_N-1:0]  w_cmd;
    logic              w_nonnop;
    logic              w_exp_hit;
    logic              w_exp_val;

    ddr_cmd_decode u_cmd_decode (
        .i_cs  (sd_CS),
        .i_ras (sd_RAS),
        .i_cas (sd_CAS),
        .i_we  (sd_WE),
        .o_cmd (w_cmd)
    );

    assign w_nonnop = |w_cmd[CMD_BST:CMD_ACT];

    // Which command advances each init step, and whether its payload is right
    always_comb begin
        w_exp_hit = 1'b0;
        w_exp_val = 1'b1;
        case (r_state)
            ST_PRE1: begin
                w_exp_hit = w_cmd[CMD_LMR];
                w_exp_val = (sd_BA == 2'b01) && (sd_A == EMR_VALUE);
            end
            ST_EMR, ST_REF2: begin
                w_exp_hit = w_cmd[CMD_LMR];
                w_exp_val = (sd_BA == 2'b00) && (sd_A == MR_VALUE);
            end
            ST_MR1:           w_exp_hit = w_cmd[CMD_PRE];
            ST_PRE2, ST_REF1: w_exp_hit = w_cmd[CMD_REF];
            default: ;
        endcase
    end

    always_comb begin
        w_flag       = '0;
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_row_next   = r_row_open;
        w_done_set   = 1'b0;

        if (r_state != ST_WAIT_CKE) begin
            if (!sd_CKE) w_flag[ERR_CKE_LOW] = 1'b1;
            if (w_nonnop) begin
                if (r_last == LAST_PRE && r_gap < RP_LIM)  w_flag[ERR_TRP]  = 1'b1;
                if (r_last == LAST_LMR && r_gap < MRD_LIM) w_flag[ERR_TMRD] = 1'b1;
                if (r_last == LAST_REF && r_gap < RFC_LIM) w_flag[ERR_TRFC] = 1'b1;
            end
        end

        case (r_state)
            ST_WAIT_CKE: begin
                if (!sd_CKE) begin
                    w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
                end else if (r_cnt >= INIT_LIM) begin
                    w_next_state = ST_NOP_HOLD;
                    w_cnt_next   = '0;
                end else begin
                    w_flag[ERR_CKE_EARLY] = 1'b1;
                end
            end
            // r_cnt doubles as a "NOP seen" marker here
            ST_NOP_HOLD: begin
                if (w_cmd[CMD_NOP]) begin
                    w_cnt_next = CNT_W'(1);
                end else if (w_cmd[CMD_PRE] && !sd_A[10]) begin
                    w_flag[ERR_PRE_A10] = 1'b1;
                end else if (w_cmd[CMD_PRE]) begin
                    if (r_cnt == '0) w_flag[ERR_SEQ] = 1'b1;
                    w_next_state = ST_PRE1;
                end else begin
                    w_flag[ERR_SEQ] = 1'b1;
                end
            end
            ST_PRE1, ST_EMR, ST_MR1, ST_PRE2, ST_REF1, ST_REF2: begin
                if (w_nonnop) begin
                    if (w_exp_hit) begin
                        if (!w_exp_val) w_flag[ERR_LMR_VAL] = 1'b1;
                        w_next_state = state_t'(r_state + 4'd1);
                        w_done_set   = (r_state == ST_REF2);
                    end else begin
                        w_flag[ERR_SEQ] = 1'b1;
                    end
                end
            end
            ST_MR2: begin
                if (w_nonnop) w_flag[ERR_SEQ] = 1'b1;
                w_next_state = ST_READY;
                w_cnt_next   = '0;
            end
            ST_READY: begin
                if (w_cmd[CMD_REF]) begin
                    if (|r_row_open) w_flag[ERR_ROW_OPEN] = 1'b1;
                    w_cnt_next = '0;
                end else if (r_cnt == REFI_LIM) begin
                    w_flag[ERR_TREFI] = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
                if (w_cmd[CMD_ACT]) begin
                    if (r_row_open[sd_BA]) w_flag[ERR_ROW_OPEN] = 1'b1;
                    else w_row_next[sd_BA] = 1'b1;
                end
                if ((w_cmd[CMD_RD] || w_cmd[CMD_WR]) && !r_row_open[sd_BA])
                    w_flag[ERR_ROW_CLOSED] = 1'b1;
                if (w_cmd[CMD_PRE]) begin
                    if (sd_A[10]) w_row_next = '0;
                    else w_row_next[sd_BA] = 1'b0;
                end
            end
            default: w_next_state = ST_WAIT_CKE;
        endcase
    end

    // Lowest-numbered simultaneous cause wins
    always_comb begin
        w_code = ERR_NONE;
        for (int i = 11; i >= 1; i--) begin
            if (w_flag[i]) w_code = 4'(i);
        end
    end

    always_ff @(posedge clk133_p or negedge rst) begin
        if (!rst) r_state <= ST_WAIT_CKE;
        else      r_state <= w_next_state;
    end

    always_ff @(posedge clk133_p or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_gap       <= '0;
            r_last      <= LAST_NONE;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_init_done <= 1'b0;
            r_row_open  <= '0;
        end else begin
            r_cnt      <= w_cnt_next;
            r_row_open <= w_row_next;
            if (!r_err && (w_flag != '0)) begin
                r_err      <= 1'b1;
                r_err_code <= w_code;
            end
            if (w_done_set && !r_err && (w_flag == '0)) r_init_done <= 1'b1;
            if (r_state == ST_WAIT_CKE) begin
                r_gap  <= '0;
                r_last <= LAST_NONE;
            end else if (w_nonnop) begin
                r_gap  <= GAP_W'(1);
                r_last <= w_cmd[CMD_PRE] ? LAST_PRE :
                          w_cmd[CMD_LMR] ? LAST_LMR :
                          w_cmd[CMD_REF] ? LAST_REF : LAST_NONE;
            end else if (r_gap != '1) begin
                r_gap <= r_gap + 1'b1;
            end
        end
    end

    assign init_done = r_init_done;
    assign err       = r_err;
    assign err_code  = r_err_code;
    assign row_open  = r_row_open;
    assign state     = r_state;

endmodule

// File: tb/tb_ddr_init_monitor.sv
// tb/tb_ddr_init_monitor.sv - directed self-checking bench for ddr_init_monitor
module tb_ddr_init_monitor;

    // CKE-low wait scaled down 100x to keep every run short
    localparam int          INIT_CYC = 266;
    localparam int          EARLY    = 260;
    localparam logic [12:0] MRV      = 13'h0021;
    localparam logic [12:0] A10      = 13'h0400;
    localparam logic [2:0]  C_NOP    = 3'b111;
    localparam logic [2:0]  C_ACT    = 3'b011;
    localparam logic [2:0]  C_RD     = 3'b101;
    localparam logic [2:0]  C_PRE    = 3'b010;
    localparam logic [2:0]  C_REF    = 3'b001;
    localparam logic [2:0]  C_LMR    = 3'b000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cke, cs, ras, cas, we;
    logic [1:0]  ba;
    logic [12:0] a;
    logic        init_done, err;
    logic [3:0]  err_code, row_open, state;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    ddr_init_monitor #(.INIT_CYCLES(INIT_CYC)) dut (
        .clk133_p  (clk),
        .rst       (rst),
        .sd_CKE    (cke),
        .sd_CS     (cs),
        .sd_RAS    (ras),
        .sd_CAS    (cas),
        .sd_WE     (we),
        .sd_BA     (ba),
        .sd_A      (a),
        .init_done (init_done),
        .err       (err),
        .err_code  (err_code),
        .row_open  (row_open),
        .state     (state)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input logic c, input logic [2:0] rcw, input logic [1:0] b, input logic [12:0] addr);
        cke = c;
        cs  = 1'b0;
        {ras, cas, we} = rcw;
        ba  = b;
        a   = addr;
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, C_NOP, 2'd0, 13'd0);
    endtask

    task automatic lows(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, C_NOP, 2'd0, 13'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        cke = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    task automatic init_seq(input int ref_gap, input logic [12:0] mr2_a, input bit stop_at_ref1);
        lows(INIT_CYC);
        nops(5);
        tick(1'b1, C_PRE, 2'd0, A10);
        nops(2);
        tick(1'b1, C_LMR, 2'd1, 13'h0000);
        nops(1);
        tick(1'b1, C_LMR, 2'd0, MRV);
        nops(1);
        tick(1'b1, C_PRE, 2'd0, A10);
        nops(2);
        tick(1'b1, C_REF, 2'd0, 13'd0);
        if (!stop_at_ref1) begin
            nops(ref_gap);
            tick(1'b1, C_REF, 2'd0, 13'd0);
            nops(10);
            tick(1'b1, C_LMR, 2'd0, mr2_a);
        end
    endtask

    initial begin
        rst = 1'b0;
        cke = 1'b0;
        cs  = 1'b0;
        {ras, cas, we} = C_NOP;
        ba  = 2'd0;
        a   = 13'd0;
        #12;
        check("reset_state", state, 16'd0);
        check("reset_init_done", init_done, 16'd0);
        check("reset_err", err, 16'd0);
        check("reset_err_code", err_code, 16'd0);
        check("reset_row_open", row_open, 16'd0);
        @(negedge clk);
        rst = 1'b1;

        // legal init, then bank bookkeeping
        init_seq(10, MRV, 1'b0);
        check("legal_init_done", init_done, 16'd1);
        check("legal_err", err, 16'd0);
        check("legal_state_mr2", state, 16'd8);
        nops(1);
        check("legal_state_ready", state, 16'd9);
        nops(2);
        tick(1'b1, C_ACT, 2'd2, 13'd0);
        check("act_b2_row", row_open, 16'h4);
        tick(1'b1, C_ACT, 2'd0, 13'd0);
        check("act_b0_row", row_open, 16'h5);
        tick(1'b1, C_PRE, 2'd2, 13'd0);
        check("pre_b2_row", row_open, 16'h1);
        nops(2);
        tick(1'b1, C_PRE, 2'd0, A10);
        check("pre_all_row", row_open, 16'h0);
        check("pre_all_err", err, 16'd0);
        nops(2);
        tick(1'b1, C_RD, 2'd1, 13'd0);
        check("rd_closed_err", err, 16'd1);
        check("rd_closed_code", err_code, 16'd8);
        tick(1'b1, C_ACT, 2'd1, 13'd0);
        tick(1'b1, C_ACT, 2'd1, 13'd0);
        check("first_cause_held", err_code, 16'd8);

        // double ACT to one bank
        pulse_reset();
        check("rearm_err", err, 16'd0);
        init_seq(10, MRV, 1'b0);
        nops(3);
        tick(1'b1, C_ACT, 2'd2, 13'd0);
        tick(1'b1, C_ACT, 2'd2, 13'd0);
        check("act_act_code", err_code, 16'd7);

        // refresh interval expiry
        pulse_reset();
        init_seq(10, MRV, 1'b0);
        nops(1);
        nops(1000);
        check("refi_not_yet", err, 16'd0);
        nops(100);
        check("refi_code", err_code, 16'd9);
        check("refi_done_kept", init_done, 16'd1);

        // CKE raised early
        pulse_reset();
        lows(EARLY);
        tick(1'b1, C_NOP, 2'd0, 13'd0);
        check("cke_early_err", err, 16'd1);
        check("cke_early_code", err_code, 16'd1);
        nops(5);
        check("cke_early_no_done", init_done, 16'd0);
        check("cke_early_state", state, 16'd0);

        // second REF too soon
        pulse_reset();
        init_seq(5, MRV, 1'b0);
        check("trfc_code", err_code, 16'd5);
        check("trfc_no_done", init_done, 16'd0);

        // MR2 value mismatch
        pulse_reset();
        init_seq(10, 13'h0031, 1'b0);
        check("mr2_val_code", err_code, 16'd6);
        check("mr2_val_no_done", init_done, 16'd0);
        check("mr2_val_state", state, 16'd8);

        // early and wrong EMR in one cycle: tRP beats payload mismatch
        pulse_reset();
        lows(INIT_CYC);
        nops(5);
        tick(1'b1, C_PRE, 2'd0, A10);
        nops(1);
        tick(1'b1, C_LMR, 2'd0, 13'd0);
        check("lowest_code_wins", err_code, 16'd3);

        // reset pulse while waiting in REF1
        pulse_reset();
        init_seq(10, MRV, 1'b1);
        check("mid_ref1_state", state, 16'd6);
        rst = 1'b0;
        #1;
        check("mid_rst_state", state, 16'd0);
        check("mid_rst_done", init_done, 16'd0);
        check("mid_rst_err", err, 16'd0);
        check("mid_rst_code", err_code, 16'd0);
        check("mid_rst_row", row_open, 16'd0);
        #1;
        rst = 1'b1;
        lows(10);
        tick(1'b1, C_NOP, 2'd0, 13'd0);
        check("rewait_required", err_code, 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ddr_init_monitor.md
DDR_INIT_MONITOR -- requirements
Module: ddr_init_monitor

Interface
REQ-001 SHALL have parameters: INIT_CYCLES, default 26600, minimum cycles CKE is held low after reset (200 us at 7.518 ns).
REQ-002 SHALL have parameters: T_RP 3, T_MRD 2, T_RFC 11, T_REFI 1037, MR_VALUE 13'h0021, EMR_VALUE 13'h0000 (all in clk133_p cycles).
REQ-003 SHALL have ports: clk133_p  in  1  sole clock; SDRAM pins sampled on its rising edge.
REQ-004 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: sd_CKE, sd_CS, sd_RAS, sd_CAS, sd_WE  in  1 each  DDR command pins.
REQ-006 SHALL have ports: sd_BA  in  2, bank address; sd_A  in  13, address.
REQ-007 SHALL have ports: init_done  out  1, init sequence completed legally.
REQ-008 SHALL have ports: err  out  1, sticky error flag; err_code  out  4, first error cause.
REQ-009 SHALL have ports: row_open  out  4, per-bank open-row flags; state  out  4, current state, for debug.

Function
REQ-010 SHALL decode the command as {RAS,CAS,WE}: 111 NOP, 011 ACT, 101 RD, 100 WR, 010 PRE, 001 REF, 000 LMR, 110 BST; sd_CS=1 SHALL be treated as NOP.
REQ-011 SHALL step through states WAIT_CKE, NOP_HOLD, PRE1, EMR, MR1, PRE2, REF1, REF2, MR2, READY in that order.
REQ-012 WAIT_CKE: count cycles with sd_CKE=0; CKE rising before INIT_CYCLES -> err_code 1; CKE rising at or after INIT_CYCLES -> NOP_HOLD.
REQ-013 NOP_HOLD: at least 1 NOP required; the first non-NOP SHALL be PRE with A[10]=1, otherwise err_code 2; PRE with A[10]=0 -> err_code 10.
REQ-014 Between init steps, intermediate cycles SHALL be NOP; any other command -> err_code 2.
REQ-015 Next command earlier than T_RP after PRE, T_MRD after LMR, or T_RFC after REF (spacing counted issue-to-issue) -> err_code 3, 4 or 5 respectively.
REQ-016 EMR step SHALL require LMR with BA=01 and A=EMR_VALUE; MR1/MR2 SHALL require LMR with BA=00 and A=MR_VALUE; mismatch -> err_code 6.
REQ-017 Sequence: PRE1 is followed by EMR, EMR by MR1, MR1 by PRE2, PRE2 by REF1, REF1 by REF2, REF2 by MR2, MR2 by READY.
REQ-018 init_done SHALL rise the cycle after a legal MR2 LMR is sampled and remain 1 until reset.
REQ-019 READY, ACT: ACT to a bank with row_open set -> err_code 7; otherwise set row_open[BA].
REQ-020 READY, RD/WR: RD or WR to a bank with row_open clear -> err_code 8.
REQ-021 READY, PRE: PRE with A[10]=1 SHALL clear all row_open bits; PRE with A[10]=0 SHALL clear row_open[BA] only.
REQ-022 READY, REF: REF with any row_open set -> err_code 7.
REQ-023 READY SHALL keep a refresh-interval counter cleared by REF; reaching T_REFI without REF -> err_code 9, and the counter SHALL saturate rather than wrap.
REQ-024 err SHALL set on the first error; err_code SHALL hold the first cause; later errors SHALL be ignored; monitoring SHALL continue in the expected state.
REQ-025 If two error causes occur in the same cycle, the lowest code SHALL win.
REQ-026 sd_CKE falling after NOP_HOLD is entered -> err_code 11.

Reset
REQ-027 When rst=0, asynchronously: state=WAIT_CKE, all counters 0, init_done=0, err=0, err_code=0, row_open=0.
REQ-028 Reset asserted mid-sequence SHALL abandon progress; after release the monitor SHALL require the full INIT_CYCLES wait again.

Structure
REQ-029 A shared package ddr_pkg SHALL hold the command encodings, state encodings, err_code constants and the timing defaults.
REQ-030 One sub-module, ddr_cmd_decode, SHALL map the pins to a one-hot command vector (combinational); all sequencing SHALL live in ddr_init_monitor.

Verification
REQ-031 Legal sequence at 7.518 ns (CKE low 26600 cycles, 5 NOP, PRE A10=1, 2 NOP, LMR BA=01 A=0, NOP, LMR BA=00 A=0x021, NOP, PRE, 2 NOP, REF, 10 NOP, REF, 10 NOP, LMR BA=00 A=0x021) -> init_done=1 and err=0.
REQ-032 CKE raised at cycle 26000 -> err=1, err_code=1, init_done stays 0.
REQ-033 REF then only 5 NOPs before the second REF -> err_code=5.
REQ-034 MR2 with A=0x031 -> err_code=6.
REQ-035 After init: ACT bank2, ACT bank2 -> err_code=7; separate run: RD bank1 with no open row -> err_code=8; separate run: PRE A10=1 -> row_open=0.
REQ-036 After init, no REF for 1037 cycles -> err_code=9; reset pulse mid-REF1 -> all outputs 0 and state=WAIT_CKE.
